// File: rtl/fetch_mo.sv
// Instruction fetch front end: issues block-aligned bus reads under a credit limit,
// buffers in-order responses and hands them to decode with per-slot valid masks.
module fetch_mo #(
   parameter int                    ADDR_WIDTH        = 32,
   parameter int                    INSTRUCTION_WIDTH = 32,
   parameter int                    FETCH_WIDTH       = 4,
   parameter int                    MAX_OUTSTANDING   = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC          = 32'h80000000
) (
   input  logic                                        clk,
   input  logic                                        rst,
   output logic                                        fetch_bus_read_req,
   output logic [ADDR_WIDTH-1:0]                       fetch_bus_addr,
   input  logic                                        bus_fetch_read_ack,
   input  logic                                        bus_fetch_data_valid,
   input  logic [FETCH_WIDTH*INSTRUCTION_WIDTH-1:0]    bus_fetch_data,
   input  logic                                        bus_fetch_error,
   input  logic                                        decode_fetch_ready,
   output logic                                        fetch_decode_push,
   output logic [FETCH_WIDTH-1:0]                      fetch_decode_valid,
   output logic [FETCH_WIDTH*ADDR_WIDTH-1:0]           fetch_decode_pc,
   output logic [FETCH_WIDTH*INSTRUCTION_WIDTH-1:0]    fetch_decode_value,
   output logic                                        fetch_decode_has_exception,
   output logic [ADDR_WIDTH-1:0]                       fetch_decode_exception_value,
   input  logic                                        commit_redirect_valid,
   input  logic [ADDR_WIDTH-1:0]                       commit_redirect_pc,
   output logic                                        fetch_csrf_credit_stall_add
);

   localparam int DW          = FETCH_WIDTH * INSTRUCTION_WIDTH;
   localparam int BLOCK_BYTES = FETCH_WIDTH * 4;
   localparam int CW          = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW          = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(BLOCK_BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] BLOCK_STEP = ADDR_WIDTH'(BLOCK_BYTES);
   localparam logic [CW-1:0]         MAX_CNT    = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0]         LAST_PTR   = PW'(MAX_OUTSTANDING - 1);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == LAST_PTR) begin
         ptr_inc = {PW{1'b0}};
      end else begin
         ptr_inc = p + PW'(1'b1);
      end
   endfunction

   state_t                  state_r;
   logic [ADDR_WIDTH-1:0]   pc_r;
   logic [PW-1:0]           rq_wr_r, rq_rd_r;
   logic [PW-1:0]           buf_wr_r, buf_rd_r;
   logic [CW-1:0]           buf_cnt_r, inflight_r, drop_r;

   logic [ADDR_WIDTH-1:0]   rq_pc_mem    [MAX_OUTSTANDING];
   logic [DW-1:0]           buf_data_mem [MAX_OUTSTANDING];
   logic [ADDR_WIDTH-1:0]   buf_pc_mem   [MAX_OUTSTANDING];
   logic                    buf_err_mem  [MAX_OUTSTANDING];

   logic                    active_s, credit_ok_s, req_s, accept_s;
   logic                    buf_empty_s, push_s, keep_s, head_ok_s;
   logic [ADDR_WIDTH-1:0]   head_pc_s, head_base_s, head_slot_s;
   logic                    head_err_s;
   logic [DW-1:0]           head_data_s;
   logic [FETCH_WIDTH-1:0]  valid_s;
   logic [FETCH_WIDTH*ADDR_WIDTH-1:0] slot_pc_s;

   // Credit counts both in-flight reads and buffered blocks, so the buffer can never overflow.
   assign active_s    = rst && (state_r == RUN) && !commit_redirect_valid;
   assign credit_ok_s = ({1'b0, inflight_r} + {1'b0, buf_cnt_r}) < {1'b0, MAX_CNT};
   assign req_s       = active_s && credit_ok_s;
   assign accept_s    = req_s && bus_fetch_read_ack;
   assign buf_empty_s = (buf_cnt_r == {CW{1'b0}});
   assign push_s      = active_s && !buf_empty_s && decode_fetch_ready;
   assign keep_s      = rst && bus_fetch_data_valid && (drop_r == {CW{1'b0}})
                        && (state_r == RUN) && !commit_redirect_valid;
   assign head_ok_s   = rst && !buf_empty_s;

   assign head_pc_s   = buf_pc_mem[buf_rd_r];
   assign head_err_s  = buf_err_mem[buf_rd_r];
   assign head_data_s = buf_data_mem[buf_rd_r];
   assign head_base_s = head_pc_s & ~OFF_MASK;
   assign head_slot_s = (head_pc_s & OFF_MASK) >> 2;

   // Per-slot mask and PCs for the head block; an errored block exposes only its first valid slot.
   always_comb begin
      valid_s   = {FETCH_WIDTH{1'b0}};
      slot_pc_s = {(FETCH_WIDTH*ADDR_WIDTH){1'b0}};
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         slot_pc_s[i*ADDR_WIDTH +: ADDR_WIDTH] = head_base_s + ADDR_WIDTH'(i * 4);
         if (head_err_s) begin
            valid_s[i] = (head_slot_s == ADDR_WIDTH'(i));
         end else begin
            valid_s[i] = (head_slot_s <= ADDR_WIDTH'(i));
         end
      end
   end

   // Output drive; everything is held at zero while reset is asserted.
   always_comb begin
      fetch_bus_read_req          = req_s;
      fetch_decode_push           = push_s;
      fetch_csrf_credit_stall_add = active_s && !credit_ok_s;
      if (rst) begin
         fetch_bus_addr     = pc_r & ~OFF_MASK;
         fetch_decode_pc    = slot_pc_s;
         fetch_decode_value = head_data_s;
      end else begin
         fetch_bus_addr     = {ADDR_WIDTH{1'b0}};
         fetch_decode_pc    = {(FETCH_WIDTH*ADDR_WIDTH){1'b0}};
         fetch_decode_value = {DW{1'b0}};
      end
      if (head_ok_s) begin
         fetch_decode_valid         = valid_s;
         fetch_decode_has_exception = head_err_s;
         if (head_err_s) begin
            fetch_decode_exception_value = head_pc_s;
         end else begin
            fetch_decode_exception_value = {ADDR_WIDTH{1'b0}};
         end
      end else begin
         fetch_decode_valid           = {FETCH_WIDTH{1'b0}};
         fetch_decode_has_exception   = 1'b0;
         fetch_decode_exception_value = {ADDR_WIDTH{1'b0}};
      end
   end

   // Storage arrays; only the pointers need reset.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         rq_pc_mem[rq_wr_r] <= pc_r;
      end
      if (keep_s) begin
         buf_data_mem[buf_wr_r] <= bus_fetch_data;
         buf_pc_mem[buf_wr_r]   <= rq_pc_mem[rq_rd_r];
         buf_err_mem[buf_wr_r]  <= bus_fetch_error;
      end
   end

   // Control state: PC, RUN/HALT, queue pointers and in-flight/drop accounting.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= RUN;
         pc_r       <= RESET_PC;
         rq_wr_r    <= {PW{1'b0}};
         rq_rd_r    <= {PW{1'b0}};
         buf_wr_r   <= {PW{1'b0}};
         buf_rd_r   <= {PW{1'b0}};
         buf_cnt_r  <= {CW{1'b0}};
         inflight_r <= {CW{1'b0}};
         drop_r     <= {CW{1'b0}};
      end else begin
         if (accept_s) begin
            rq_wr_r <= ptr_inc(rq_wr_r);
         end
         if (bus_fetch_data_valid) begin
            rq_rd_r <= ptr_inc(rq_rd_r);
         end
         case ({accept_s, bus_fetch_data_valid})
            2'b10:   inflight_r <= inflight_r + CW'(1'b1);
            2'b01:   inflight_r <= inflight_r - CW'(1'b1);
            default: inflight_r <= inflight_r;
         endcase

         if (commit_redirect_valid) begin
            // Every read still outstanding belongs to the old stream; one returning now is already gone.
            pc_r      <= commit_redirect_pc;
            state_r   <= RUN;
            buf_wr_r  <= {PW{1'b0}};
            buf_rd_r  <= {PW{1'b0}};
            buf_cnt_r <= {CW{1'b0}};
            drop_r    <= inflight_r - CW'(bus_fetch_data_valid);
         end else begin
            if (accept_s) begin
               pc_r <= (pc_r & ~OFF_MASK) + BLOCK_STEP;
            end
            if (bus_fetch_data_valid && (drop_r != {CW{1'b0}})) begin
               drop_r <= drop_r - CW'(1'b1);
            end
            if (push_s && head_err_s) begin
               state_r   <= HALT;
               buf_wr_r  <= {PW{1'b0}};
               buf_rd_r  <= {PW{1'b0}};
               buf_cnt_r <= {CW{1'b0}};
            end else begin
               if (keep_s) begin
                  buf_wr_r <= ptr_inc(buf_wr_r);
               end
               if (push_s) begin
                  buf_rd_r <= ptr_inc(buf_rd_r);
               end
               case ({keep_s, push_s})
                  2'b10:   buf_cnt_r <= buf_cnt_r + CW'(1'b1);
                  2'b01:   buf_cnt_r <= buf_cnt_r - CW'(1'b1);
                  default: buf_cnt_r <= buf_cnt_r;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_mo.sv
// Bench for fetch_mo: a directed cycle table, a mid-run reset sequence and a
// randomized run checked against a queue-based model of the fetch stream.
module tb_fetch_mo;

   localparam int AW = 32;
   localparam int IW = 32;
   localparam int FW = 4;
   localparam int MAXO = 2;
   localparam logic [31:0] RPC = 32'h80000000;

   logic             clk = 1'b0;
   logic             rst;
   logic             req;
   logic [AW-1:0]    addr;
   logic             ack, dv, berr, rdy, redir;
   logic [FW*IW-1:0] bdata;
   logic [AW-1:0]    rpc;
   logic             push;
   logic [FW-1:0]    vmask;
   logic [FW*AW-1:0] dpc;
   logic [FW*IW-1:0] dval;
   logic             exc;
   logic [AW-1:0]    excv;
   logic             stall;

   int n_pass = 0;
   int n_total = 0;

   fetch_mo dut (
      .clk(clk), .rst(rst),
      .fetch_bus_read_req(req), .fetch_bus_addr(addr),
      .bus_fetch_read_ack(ack), .bus_fetch_data_valid(dv),
      .bus_fetch_data(bdata), .bus_fetch_error(berr),
      .decode_fetch_ready(rdy), .fetch_decode_push(push),
      .fetch_decode_valid(vmask), .fetch_decode_pc(dpc),
      .fetch_decode_value(dval), .fetch_decode_has_exception(exc),
      .fetch_decode_exception_value(excv),
      .commit_redirect_valid(redir), .commit_redirect_pc(rpc),
      .fetch_csrf_credit_stall_add(stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ack, dv, err, rdy, redir;
      logic [31:0] rpc, rsp;
      logic e_req;
      logic [31:0] e_addr;
      logic e_push;
      logic [3:0] e_valid;
      logic [31:0] e_pc0;
      logic e_exc, e_stall;
   } vec_t;

   typedef struct { logic [31:0] pc; int unsigned ep; } req_t;
   typedef struct { logic [31:0] pc; logic [127:0] data; logic err; } blk_t;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [127:0] mkdata(input logic [31:0] a);
      logic [127:0] d;
      for (int i = 0; i < FW; i++) d[i*32 +: 32] = (a + 32'(4*i)) ^ 32'hDEAD0000;
      return d;
   endfunction

   function automatic logic [127:0] pcs_of(input logic [31:0] sp);
      logic [127:0] r;
      logic [31:0] base;
      base = sp - (sp % 32'd16);
      for (int i = 0; i < FW; i++) r[i*32 +: 32] = base + 32'(4*i);
      return r;
   endfunction

   function automatic logic [3:0] mask_of(input logic [31:0] sp, input logic err);
      int first;
      logic [3:0] m;
      first = int'((sp % 32'd16) / 32'd4);
      if (err) m = 4'b0001 << first;
      else     m = 4'b1111 << first;
      return m;
   endfunction

   function automatic vec_t v(input logic a, d, e, r, x, input logic [31:0] tpc, rsp,
                              input logic ereq, input logic [31:0] eaddr, input logic epush,
                              input logic [3:0] evalid, input logic [31:0] epc0,
                              input logic eexc, estall);
      vec_t t;
      t.ack = a; t.dv = d; t.err = e; t.rdy = r; t.redir = x; t.rpc = tpc; t.rsp = rsp;
      t.e_req = ereq; t.e_addr = eaddr; t.e_push = epush; t.e_valid = evalid;
      t.e_pc0 = epc0; t.e_exc = eexc; t.e_stall = estall;
      return t;
   endfunction

   task automatic drive(input logic a, d, e, r, x, input logic [31:0] tpc, input logic [127:0] data);
      @(negedge clk);
      ack = a; dv = d; berr = e; rdy = r; redir = x; rpc = tpc; bdata = data;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; ack = 1'b1; dv = 1'b0; berr = 1'b0; rdy = 1'b1; redir = 1'b0;
      rpc = 32'h0; bdata = '0;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("rst_req", req, 1'b0);
         chk("rst_addr", addr, 32'h0);
         chk("rst_push", push, 1'b0);
         chk("rst_valid", vmask, 4'h0);
         chk("rst_stall", stall, 1'b0);
         @(posedge clk);
      end
      #1 rst = 1'b1;
   endtask

   vec_t tbl[23];
   req_t acc_q[$];
   blk_t bufq[$];

   initial begin
      logic [31:0] m_pc, epc_v;
      logic halted, e_req, e_push, e_stall, keep;
      int unsigned epoch;
      int bias;
      req_t rq;
      blk_t bk;
      logic a_r, d_r, er_r, rd_r, x_r;
      logic [31:0] t_r;
      logic [127:0] dat_r;

      tbl[0]  = v(1,0,0,1,0, 0, 0,            1, 32'h80000000, 0, 4'h0, 0, 0, 0);
      tbl[1]  = v(1,1,0,1,0, 0, 32'h80000000, 1, 32'h80000010, 0, 4'h0, 0, 0, 0);
      tbl[2]  = v(1,1,0,1,0, 0, 32'h80000010, 0, 0, 1, 4'hF, 32'h80000000, 0, 1);
      tbl[3]  = v(1,0,0,1,0, 0, 0,            1, 32'h80000020, 1, 4'hF, 32'h80000010, 0, 0);
      tbl[4]  = v(1,1,0,1,0, 0, 32'h80000020, 1, 32'h80000030, 0, 4'h0, 0, 0, 0);
      tbl[5]  = v(1,1,0,1,0, 0, 32'h80000030, 0, 0, 1, 4'hF, 32'h80000020, 0, 1);
      tbl[6]  = v(1,0,0,1,0, 0, 0,            1, 32'h80000040, 1, 4'hF, 32'h80000030, 0, 0);
      tbl[7]  = v(1,0,0,1,0, 0, 0,            1, 32'h80000050, 0, 4'h0, 0, 0, 0);
      tbl[8]  = v(1,0,0,1,1, 32'h80000108, 0, 0, 0, 0, 4'h0, 0, 0, 0);
      tbl[9]  = v(0,1,0,1,0, 0, 32'h80000040, 0, 0, 0, 4'h0, 0, 0, 1);
      tbl[10] = v(1,1,0,1,0, 0, 32'h80000050, 1, 32'h80000100, 0, 4'h0, 0, 0, 0);
      tbl[11] = v(0,1,0,1,0, 0, 32'h80000100, 1, 32'h80000110, 0, 4'h0, 0, 0, 0);
      tbl[12] = v(0,0,0,1,0, 0, 0,            1, 32'h80000110, 1, 4'hC, 32'h80000100, 0, 0);
      tbl[13] = v(1,0,0,1,0, 0, 0,            1, 32'h80000110, 0, 4'h0, 0, 0, 0);
      tbl[14] = v(1,1,1,1,0, 0, 32'h80000110, 1, 32'h80000120, 0, 4'h0, 0, 0, 0);
      tbl[15] = v(0,1,0,1,0, 0, 32'h80000120, 0, 0, 1, 4'h1, 32'h80000110, 1, 1);
      tbl[16] = v(1,0,0,1,0, 0, 0,            0, 0, 0, 4'h0, 0, 0, 0);
      tbl[17] = v(1,0,0,1,1, 32'h80000200, 0, 0, 0, 0, 4'h0, 0, 0, 0);
      tbl[18] = v(1,0,0,1,0, 0, 0,            1, 32'h80000200, 0, 4'h0, 0, 0, 0);
      tbl[19] = v(1,1,0,1,1, 32'h80000300, 32'h80000200, 0, 0, 0, 4'h0, 0, 0, 0);
      tbl[20] = v(1,0,0,1,0, 0, 0,            1, 32'h80000300, 0, 4'h0, 0, 0, 0);
      tbl[21] = v(0,1,0,1,0, 0, 32'h80000300, 1, 32'h80000310, 0, 4'h0, 0, 0, 0);
      tbl[22] = v(0,0,0,1,0, 0, 0,            1, 32'h80000310, 1, 4'hF, 32'h80000300, 0, 0);

      rst = 1'b0;
      do_reset();

      for (int r = 0; r < 23; r++) begin
         drive(tbl[r].ack, tbl[r].dv, tbl[r].err, tbl[r].rdy, tbl[r].redir, tbl[r].rpc,
               tbl[r].dv ? mkdata(tbl[r].rsp) : 128'h0);
         chk($sformatf("t%0d_req", r), req, tbl[r].e_req);
         chk($sformatf("t%0d_stall", r), stall, tbl[r].e_stall);
         chk($sformatf("t%0d_push", r), push, tbl[r].e_push);
         if (tbl[r].e_req) chk($sformatf("t%0d_addr", r), addr, tbl[r].e_addr);
         if (tbl[r].e_push) begin
            chk($sformatf("t%0d_valid", r), vmask, tbl[r].e_valid);
            chk($sformatf("t%0d_pcs", r), dpc, pcs_of(tbl[r].e_pc0));
            chk($sformatf("t%0d_value", r), dval, mkdata(tbl[r].e_pc0));
            chk($sformatf("t%0d_exc", r), exc, tbl[r].e_exc);
            if (tbl[r].e_exc) chk($sformatf("t%0d_excv", r), excv, tbl[r].e_pc0);
         end
      end

      // Mid-run reset with a read accepted and still outstanding.
      drive(1,0,0,0,0, 0, 128'h0);
      do_reset();
      drive(1,0,0,1,0, 0, 128'h0);
      chk("mr_req", req, 1'b1);
      chk("mr_addr", addr, 32'h80000000);
      chk("mr_push", push, 1'b0);
      drive(0,1,0,1,0, 0, mkdata(32'h80000000));
      chk("mr_req2", req, 1'b1);
      chk("mr_push2", push, 1'b0);
      drive(0,0,0,1,0, 0, 128'h0);
      chk("mr_push3", push, 1'b1);
      chk("mr_valid", vmask, 4'hF);
      chk("mr_pcs", dpc, pcs_of(32'h80000000));
      chk("mr_value", dval, mkdata(32'h80000000));

      // Randomized run against the queue model.
      do_reset();
      m_pc = RPC; halted = 1'b0; epoch = 0; bias = 1;
      acc_q.delete(); bufq.delete();
      for (int c = 0; c < 4000; c++) begin
         if (c % 150 == 0) bias = $urandom_range(0, 2);
         a_r  = ($urandom_range(0, 3) != 0);
         d_r  = (acc_q.size() > 0) && ($urandom_range(0, 2) != 0);
         er_r = d_r && ($urandom_range(0, 15) == 0);
         rd_r = (bias == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         x_r  = ($urandom_range(0, 39) == 0);
         t_r  = RPC | (32'($urandom_range(0, 255)) << 2);
         dat_r = {$urandom, $urandom, $urandom, $urandom};
         drive(a_r, d_r, er_r, rd_r, x_r, t_r, dat_r);

         e_req   = !halted && !x_r && (acc_q.size() + bufq.size() < MAXO);
         e_stall = !halted && !x_r && (acc_q.size() + bufq.size() >= MAXO);
         e_push  = !halted && !x_r && (bufq.size() > 0) && rd_r;
         chk("r_req", req, e_req);
         chk("r_stall", stall, e_stall);
         chk("r_push", push, e_push);
         if (e_req) chk("r_addr", addr, m_pc & ~32'hF);
         if (e_push) begin
            bk = bufq[0];
            chk("r_valid", vmask, mask_of(bk.pc, bk.err));
            chk("r_pcs", dpc, pcs_of(bk.pc));
            chk("r_value", dval, bk.data);
            chk("r_exc", exc, bk.err);
            if (bk.err) chk("r_excv", excv, bk.pc);
         end

         keep = 1'b0;
         epc_v = 32'h0;
         if (d_r) begin
            rq = acc_q.pop_front();
            keep = (rq.ep == epoch);
            epc_v = rq.pc;
         end
         if (x_r) begin
            epoch++;
            halted = 1'b0;
            bufq.delete();
            m_pc = t_r;
         end else begin
            if (e_push) begin
               bk = bufq.pop_front();
               if (bk.err) begin
                  halted = 1'b1;
                  bufq.delete();
               end
            end
            if (d_r && keep && !halted) begin
               bk.pc = epc_v; bk.data = dat_r; bk.err = er_r;
               bufq.push_back(bk);
            end
            if (e_req && a_r) begin
               rq.pc = m_pc; rq.ep = epoch;
               acc_q.push_back(rq);
               m_pc = (m_pc & ~32'hF) + 32'h10;
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
